// File: rtl/dcache_ecc_scrub_sched.sv
// rtl/dcache_ecc_scrub_sched.sv - background ECC scrub scheduler for dcache data/tag arrays
module dcache_ecc_scrub_sched #(
  parameter int unsigned NUM_SETS     = 256,
  parameter int unsigned SET_ASSOC    = 8,
  parameter int unsigned IDX_W        = $clog2(NUM_SETS),
  parameter int unsigned INTERVAL_W   = 16,
  parameter int unsigned STARVE_LIMIT = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic [INTERVAL_W-1:0] interval_i,
  input  logic                  func_busy_i,
  output logic                  scrub_req_o,
  output logic                  scrub_urgent_o,
  output logic                  scrub_we_o,
  output logic [IDX_W-1:0]      scrub_idx_o,
  output logic [SET_ASSOC-1:0]  wb_way_o,
  input  logic                  scrub_gnt_i,
  input  logic                  err_valid_i,
  input  logic [SET_ASSOC-1:0]  err_single_i,
  input  logic [SET_ASSOC-1:0]  err_double_i,
  output logic [15:0]           corrected_cnt_o,
  output logic                  uncorrectable_o,
  output logic                  sweep_done_o,
  output logic                  busy_o
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned POP_W    = $clog2(SET_ASSOC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RD_REQ,
    S_RD_RSP,
    S_WB_REQ
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [INTERVAL_W-1:0] cnt_q, cnt_d;
  logic [STARVE_W-1:0]   starve_q, starve_d;
  logic                  urgent_q, urgent_d;
  logic [SET_ASSOC-1:0]  wb_mask_q, wb_mask_d;
  logic [15:0]           corrected_q, corrected_d;
  logic                  uncorr_q, uncorr_d;

  logic                  in_req;
  logic                  req;
  logic                  gnt;
  logic                  advance;
  logic                  sweep_done;
  logic [SET_ASSOC-1:0]  rsp_mask;
  logic [16:0]           corr_sum;

  function automatic logic [POP_W-1:0] popcnt(input logic [SET_ASSOC-1:0] v);
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < SET_ASSOC; i++) begin
      c = c + POP_W'(v[i]);
    end
    return c;
  endfunction

  // Request stays up while a scrub is pending unless functional traffic wins; urgency overrides.
  assign in_req   = (state_q == S_RD_REQ) || (state_q == S_WB_REQ);
  assign req      = in_req && (!func_busy_i || urgent_q);
  assign gnt      = req && scrub_gnt_i;
  assign rsp_mask = err_single_i & ~err_double_i;
  assign corr_sum = {1'b0, corrected_q} + {{(17 - POP_W){1'b0}}, popcnt(wb_mask_q)};

  // Next-state and datapath updates for the scrub walk.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    urgent_d    = urgent_q;
    wb_mask_d   = wb_mask_q;
    corrected_d = corrected_q;
    uncorr_d    = 1'b0;
    advance     = 1'b0;
    sweep_done  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          cnt_d   = interval_i;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!enable_i) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (gnt) begin
          starve_d = '0;
          urgent_d = 1'b0;
          state_d  = S_RD_RSP;
        end else if (!enable_i) begin
          // Abandon the pending read; the same index is read again on re-enable.
          starve_d = '0;
          urgent_d = 1'b0;
          state_d  = S_IDLE;
        end else if (func_busy_i && !urgent_q) begin
          starve_d = starve_q + 1'b1;
          if (starve_q == STARVE_W'(STARVE_LIMIT - 1)) begin
            urgent_d = 1'b1;
          end
        end
      end
      S_RD_RSP: begin
        // A missing response is treated as a clean read.
        if (err_valid_i) begin
          wb_mask_d = rsp_mask;
          uncorr_d  = |err_double_i;
          if (rsp_mask != '0) begin
            state_d = S_WB_REQ;
          end else begin
            advance = 1'b1;
          end
        end else begin
          wb_mask_d = '0;
          advance   = 1'b1;
        end
      end
      S_WB_REQ: begin
        // Write-back always completes, even if scrubbing is disabled meanwhile.
        if (gnt) begin
          starve_d    = '0;
          urgent_d    = 1'b0;
          corrected_d = corr_sum[16] ? 16'hFFFF : corr_sum[15:0];
          advance     = 1'b1;
        end else if (func_busy_i && !urgent_q) begin
          starve_d = starve_q + 1'b1;
          if (starve_q == STARVE_W'(STARVE_LIMIT - 1)) begin
            urgent_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (advance) begin
      idx_d      = idx_q + IDX_W'(1);
      sweep_done = (idx_q == IDX_W'(NUM_SETS - 1));
      if (enable_i) begin
        cnt_d   = interval_i;
        state_d = S_WAIT;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      starve_q    <= '0;
      urgent_q    <= 1'b0;
      wb_mask_q   <= '0;
      corrected_q <= '0;
      uncorr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      urgent_q    <= urgent_d;
      wb_mask_q   <= wb_mask_d;
      corrected_q <= corrected_d;
      uncorr_q    <= uncorr_d;
    end
  end

  assign scrub_req_o     = req;
  assign scrub_urgent_o  = urgent_q;
  assign scrub_we_o      = (state_q == S_WB_REQ);
  assign scrub_idx_o     = in_req ? idx_q : '0;
  assign wb_way_o        = (state_q == S_WB_REQ) ? wb_mask_q : '0;
  assign corrected_cnt_o = corrected_q;
  assign uncorrectable_o = uncorr_q;
  assign sweep_done_o    = sweep_done;
  assign busy_o          = (state_q != S_IDLE) && (state_q != S_WAIT);

endmodule
